// File: rtl/seq_squarer.sv
// rtl/seq_squarer.sv - iterative radix-2 shift-add squarer with valid/ready handshakes
// Optional macro SQR_SIGNED_EN: treat a as two's complement and square its magnitude.
module seq_squarer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y,
  output logic                 busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;

  logic [WIDTH-1:0]     w_operand;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_acc_next;

`ifdef SQR_SIGNED_EN
  // The most negative value negates to itself, which reads correctly as unsigned 2^(WIDTH-1).
  assign w_operand = a[WIDTH-1] ? (~a + 1'b1) : a;
`else
  assign w_operand = a;
`endif

  assign w_addend   = r_mplier[0] ? (r_mcand << r_cnt) : '0;
  assign w_acc_next = r_acc + w_addend;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand  <= {{WIDTH{1'b0}}, w_operand};
            r_mplier <= w_operand;
            r_acc    <= '0;
            r_cnt    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_next;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            y         <= w_acc_next;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
